// File: rtl/ldl_fifo_ws_v2_if.sv
// Write-side bus of the LDL FIFO pointer controller, generation 2.
// The master drives the write request, the read pointer and the status controls.
// The slave (the controller) returns the pointer, the RAM write port and the status.
interface ldl_fifo_ws_v2_if #(
   parameter int unsigned AW = 8
);
   logic          we;
   logic [AW:0]   afull_th;
   logic          stat_clr;
   logic [AW:0]   r_pt;
   logic [AW:0]   w_pt;
   logic [AW-1:0] wa;
   logic          mw;
   logic          full;
   logic          afull;
   logic [AW:0]   wcnt;
   logic          ovf;
   logic [AW:0]   peak;

   modport master (
      output we, afull_th, stat_clr, r_pt,
      input  w_pt, wa, mw, full, afull, wcnt, ovf, peak
   );

   modport slave (
      input  we, afull_th, stat_clr, r_pt,
      output w_pt, wa, mw, full, afull, wcnt, ovf, peak
   );
endinterface

// File: rtl/ldl_fifo_ws_v2.sv
// Write-side pointer and status controller for LDL FIFOs, generation 2.
// It tracks a binary write pointer with an extra wrap bit and derives occupancy from the read pointer.
// It exports the write pointer as binary (sync FIFO) or as registered Gray code (async FIFO).
// It also provides a runtime almost-full threshold, a sticky overflow flag and a peak-occupancy watermark.
module ldl_fifo_ws_v2 #(
   parameter int unsigned AW   = 8,
   parameter int unsigned GRAY = 0
) (
   input logic              clk,
   input logic              rst,
   ldl_fifo_ws_v2_if.slave  bus
);

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int unsigned i = AW; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

   logic [AW:0] wb_q, wb_d;
   logic [AW:0] w_pt_q, w_pt_d;
   logic [AW:0] peak_q, peak_d;
   logic        ovf_q, ovf_d;
   logic [AW:0] rb;
   logic [AW:0] wcnt;
   logic        full;
   logic        mw;

   // Occupancy, full and the write accept are derived combinationally from the current pointers.
   always_comb begin
      rb   = (GRAY != 0) ? gray2bin(bus.r_pt) : bus.r_pt;
      wcnt = wb_q - rb;
      // The top bit of the occupancy is set from exactly 2^AW upwards.
      // Values above 2^AW can only come from pointer corruption, and they still read as full.
      full = wcnt[AW];
      mw   = bus.we & ~full;
   end

   // Next-state values of the pointer, the exported pointer and the statistics.
   always_comb begin
      wb_d = wb_q + {{AW{1'b0}}, mw};
      // The exported pointer is encoded from the next binary value and registered on the same edge as wb.
      // As a result, it never has a combinational path and changes one Gray bit per accepted write.
      w_pt_d = (GRAY != 0) ? bin2gray(wb_d) : wb_d;
      ovf_d  = ovf_q;
      if (bus.we && full) begin
         ovf_d = 1'b1;
      end else if (bus.stat_clr) begin
         ovf_d = 1'b0;
      end
      // A clear restarts the watermark from the current level rather than from zero.
      if (bus.stat_clr) begin
         peak_d = wcnt;
      end else if (wcnt > peak_q) begin
         peak_d = wcnt;
      end else begin
         peak_d = peak_q;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_q   <= '0;
         w_pt_q <= '0;
         ovf_q  <= 1'b0;
         peak_q <= '0;
      end else begin
         wb_q   <= wb_d;
         w_pt_q <= w_pt_d;
         ovf_q  <= ovf_d;
         peak_q <= peak_d;
      end
   end

   // Output mapping.
   always_comb begin
      bus.w_pt  = w_pt_q;
      bus.wa    = wb_q[AW-1:0];
      bus.mw    = mw;
      bus.full  = full;
      bus.afull = (wcnt >= bus.afull_th);
      bus.wcnt  = wcnt;
      bus.ovf   = ovf_q;
      bus.peak  = peak_q;
   end

   // In Gray mode the exported pointer never moves by more than one bit per edge outside reset.
   generate
      if (GRAY != 0) begin : g_gray_chk
         a_gray_step : assert property (@(posedge clk) disable iff (rst)
            !$past(rst) |-> ($countones(w_pt_q ^ $past(w_pt_q)) <= 1));
      end
   endgenerate

endmodule

// File: tb/tb_ldl_fifo_ws_v2.sv
// Directed bench for the write-side FIFO controller with AW=3.
// dut0 is the binary (sync) build and dut1 is the Gray (async) build.
module tb_ldl_fifo_ws_v2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ldl_fifo_ws_v2_if #(.AW(3)) bus0 ();
   ldl_fifo_ws_v2_if #(.AW(3)) bus1 ();

   ldl_fifo_ws_v2 #(.AW(3), .GRAY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   ldl_fifo_ws_v2 #(.AW(3), .GRAY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct {
      logic       we;
      logic       clr;
      logic [3:0] r_pt;
      logic [3:0] th;
      logic       mw;
      logic [2:0] wa;
      logic       full;
      logic       afull;
      logic [3:0] wcnt;
      logic [3:0] w_pt;
      logic       ovf;
      logic [3:0] peak;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic we, input logic clr, input logic [3:0] r_pt, input logic [3:0] th,
                               input logic mw, input logic [2:0] wa, input logic full, input logic afull,
                               input logic [3:0] wcnt, input logic [3:0] w_pt, input logic ovf, input logic [3:0] peak);
      vec_t v;
      v.we = we; v.clr = clr; v.r_pt = r_pt; v.th = th;
      v.mw = mw; v.wa = wa; v.full = full; v.afull = afull;
      v.wcnt = wcnt; v.w_pt = w_pt; v.ovf = ovf; v.peak = peak;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus0.we = 1'b0; bus0.stat_clr = 1'b0; bus0.r_pt = '0; bus0.afull_th = 4'd6;
      bus1.we = 1'b0; bus1.stat_clr = 1'b0; bus1.r_pt = '0; bus1.afull_th = 4'd6;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] gtab [16];
      logic [3:0] prev;

      // Columns: we clr r_pt th | mw wa full afull wcnt w_pt ovf peak
      vq.push_back(mk(0,0,0,6, 0,0,0,0,0,0,0,0)); // reset state
      vq.push_back(mk(1,0,0,6, 1,0,0,0,0,0,0,0));
      vq.push_back(mk(1,0,0,6, 1,1,0,0,1,1,0,0));
      vq.push_back(mk(1,0,0,6, 1,2,0,0,2,2,0,1));
      vq.push_back(mk(1,0,0,6, 1,3,0,0,3,3,0,2));
      vq.push_back(mk(1,0,0,6, 1,4,0,0,4,4,0,3));
      vq.push_back(mk(1,0,0,6, 1,5,0,0,5,5,0,4));
      vq.push_back(mk(1,0,0,6, 1,6,0,1,6,6,0,5)); // afull from count 6
      vq.push_back(mk(1,0,0,6, 1,7,0,1,7,7,0,6));
      vq.push_back(mk(1,0,0,6, 0,0,1,1,8,8,0,7)); // full, 9th attempt sets ovf
      vq.push_back(mk(1,0,0,6, 0,0,1,1,8,8,1,8));
      vq.push_back(mk(1,1,0,6, 0,0,1,1,8,8,1,8)); // clear with we&full: ovf stays
      vq.push_back(mk(1,0,1,6, 1,0,0,1,7,8,1,8)); // read moves: full drops, write accepted
      vq.push_back(mk(0,0,1,6, 0,1,1,1,8,9,1,8)); // wb advanced to 9
      vq.push_back(mk(0,1,6,6, 0,1,0,0,3,9,1,8)); // clear alone at count 3
      vq.push_back(mk(0,0,6,6, 0,1,0,0,3,9,0,3));
      vq.push_back(mk(0,0,9,0, 0,1,0,1,0,9,0,3)); // threshold 0: afull always
      vq.push_back(mk(0,0,1,9, 0,1,1,0,8,9,0,3)); // threshold > depth: never afull
      vq.push_back(mk(0,0,1,8, 0,1,1,1,8,9,0,8));
      vq.push_back(mk(1,0,0,6, 0,1,1,1,9,9,0,8)); // corrupt count 9 still full
      vq.push_back(mk(0,0,0,6, 0,1,1,1,9,9,1,9));

      do_reset();
      foreach (vq[i]) begin
         bus0.we = vq[i].we; bus0.stat_clr = vq[i].clr;
         bus0.r_pt = vq[i].r_pt; bus0.afull_th = vq[i].th;
         #2;
         chk($sformatf("row%0d.mw", i),    bus0.mw,    vq[i].mw);
         chk($sformatf("row%0d.wa", i),    bus0.wa,    vq[i].wa);
         chk($sformatf("row%0d.full", i),  bus0.full,  vq[i].full);
         chk($sformatf("row%0d.afull", i), bus0.afull, vq[i].afull);
         chk($sformatf("row%0d.wcnt", i),  bus0.wcnt,  vq[i].wcnt);
         chk($sformatf("row%0d.w_pt", i),  bus0.w_pt,  vq[i].w_pt);
         chk($sformatf("row%0d.ovf", i),   bus0.ovf,   vq[i].ovf);
         chk($sformatf("row%0d.peak", i),  bus0.peak,  vq[i].peak);
         tick();
      end

      // Wrap: 20 writes with the reader two entries behind.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         bus0.we = 1'b1;
         bus0.r_pt = 4'(i + 14);
         #2;
         chk($sformatf("wrap%0d.mw", i),   bus0.mw,   1);
         chk($sformatf("wrap%0d.wa", i),   bus0.wa,   i % 8);
         chk($sformatf("wrap%0d.w_pt", i), bus0.w_pt, i % 16);
         chk($sformatf("wrap%0d.full", i), bus0.full, 0);
         chk($sformatf("wrap%0d.wcnt", i), bus0.wcnt, 2);
         tick();
      end
      bus0.we = 1'b0;
      #2;
      chk("wrap.end.w_pt", bus0.w_pt, 4);

      // Gray build: 16 writes with the reader following the writer.
      gtab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
               4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
      do_reset();
      prev = '0;
      for (int i = 0; i < 16; i++) begin
         bus1.we = 1'b1;
         bus1.r_pt = gtab[i];
         #2;
         chk($sformatf("gray%0d.w_pt", i), bus1.w_pt, gtab[i]);
         chk($sformatf("gray%0d.wcnt", i), bus1.wcnt, 0);
         if (i > 0) chk($sformatf("gray%0d.step", i), $countones(bus1.w_pt ^ prev), 1);
         prev = bus1.w_pt;
         tick();
      end
      bus1.we = 1'b0;
      bus1.r_pt = 4'b1100;
      #2;
      chk("gray.end.w_pt", bus1.w_pt, 0);
      chk("gray.end.wcnt", bus1.wcnt, 8);
      chk("gray.end.full", bus1.full, 1);

      // Reset in the middle of a burst at wb=5, with ovf and peak already set.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus0.we = 1'b1; bus0.r_pt = '0;
         tick();
      end
      bus0.r_pt = 4'd13;
      #2;
      chk("mid.full", bus0.full, 1);
      chk("mid.mw", bus0.mw, 0);
      tick();
      chk("mid.ovf", bus0.ovf, 1);
      chk("mid.peak", bus0.peak, 8);
      bus0.r_pt = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      chk("rst.w_pt", bus0.w_pt, 0);
      chk("rst.ovf", bus0.ovf, 0);
      chk("rst.peak", bus0.peak, 0);
      chk("rst.wcnt", bus0.wcnt, 0);
      chk("rst.full", bus0.full, 0);
      chk("rst.mw", bus0.mw, 1);
      chk("rst.afull", bus0.afull, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
